multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 158 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: sequences fetch/decode/execute/memory/writeback
// and decodes the datapath strobes from the state and the latched opcode.
// Optional feature macro: STEP_MODE_EN (single-instruction step from IDLE).
`timescale 1ns/1ps
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       step,
  input  logic [1:0] opcode,
  input  logic       eq,
  input  logic       mem_ack,
  output logic       pc_we,
  output logic       pc_src,
  output logic       ir_we,
  output logic       reg_we,
  output logic       mem_req,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       mem_to_reg,
  output logic       alu_src,
  output logic [2:0] state,
  output logic       busy,
  output logic       done,
  output logic [7:0] instr_count
);

  localparam int unsigned StateW = 3;
  localparam int unsigned OpW    = 2;
  localparam int unsigned CountW = 8;

  localparam logic [OpW-1:0] OP_ADD    = 2'b00;
  localparam logic [OpW-1:0] OP_LOAD   = 2'b01;
  localparam logic [OpW-1:0] OP_STORE  = 2'b10;
  localparam logic [OpW-1:0] OP_BRANCH = 2'b11;

  typedef enum logic [StateW-1:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_e;

  state_e            state_q;
  state_e            state_d;
  logic [OpW-1:0]    op_q;
  logic [CountW-1:0] count_q;
  logic              retire;
  logic              start;

`ifdef STEP_MODE_EN
  // run wins over step; step only matters while sitting in IDLE
  assign start = run | step;
`else
  // step has no function in this build
  logic step_unused;
  assign step_unused = step;
  assign start       = run;
`endif

  // State, latched opcode and retired-instruction counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH) begin
        op_q <= opcode;
      end
      if (retire) begin
        count_q <= count_q + CountW'(1);
      end
    end
  end

  // Next-state and Moore strobe decode from state and latched opcode
  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    mem_req    = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        ir_we   = 1'b1;
        pc_we   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = S_EXEC;
      end
      S_EXEC: begin
        unique case (op_q)
          OP_ADD: begin
            state_d = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src = 1'b1;
            state_d = S_MEM;
          end
          OP_BRANCH: begin
            pc_src = 1'b1;
            pc_we  = eq;
            retire = 1'b1;
          end
          default: state_d = S_IDLE;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_rd  = (op_q == OP_LOAD);
        mem_wr  = (op_q == OP_STORE);
        if (mem_ack) begin
          if (op_q == OP_LOAD) begin
            state_d = S_WB;
          end else begin
            retire = 1'b1;
          end
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        mem_to_reg = (op_q == OP_LOAD);
        retire     = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // A retiring instruction always finishes; run decides whether another follows
    if (retire) begin
      state_d = run ? S_FETCH : S_IDLE;
    end
  end

  // Status outputs
  always_comb begin
    busy = (state_q != S_IDLE);
    done = retire;
  end

  assign state       = state_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: a per-instruction cycle plan is
// built from the instruction rules and compared against the DUT every cycle.
`timescale 1ns/1ps
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic [1:0] opcode = 2'b00;
  logic       eq = 1'b0;
  logic       mem_ack = 1'b0;
  logic       pc_we, pc_src, ir_we, reg_we, mem_req, mem_rd, mem_wr, mem_to_reg, alu_src;
  logic [2:0] state;
  logic       busy, done;
  logic [7:0] instr_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .opcode(opcode), .eq(eq),
    .mem_ack(mem_ack), .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .reg_we(reg_we),
    .mem_req(mem_req), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_to_reg(mem_to_reg),
    .alu_src(alu_src), .state(state), .busy(busy), .done(done), .instr_count(instr_count)
  );

  // Observed vector: {state, busy, done, pc_we, pc_src, ir_we, reg_we,
  //                   mem_req, mem_rd, mem_wr, mem_to_reg, alu_src, instr_count}
  typedef struct {
    logic        run;
    logic        step;
    logic [1:0]  opcode;
    logic        eq;
    logic        mem_ack;
    logic [21:0] exp;
  } cyc_t;

  cyc_t       plan[$];
  logic [7:0] exp_count = 8'd0;

  function automatic logic [21:0] mk(input logic [2:0] st, input logic dn, input logic pcwe,
                                     input logic pcsrc, input logic irwe, input logic regwe,
                                     input logic mreq, input logic mrd, input logic mwr,
                                     input logic m2r, input logic asrc);
    return {st, (st != 3'd0), dn, pcwe, pcsrc, irwe, regwe, mreq, mrd, mwr, m2r, asrc, exp_count};
  endfunction

  // Random values on every input the current cycle should not care about
  function automatic cyc_t noise(input logic r);
    cyc_t c;
    c.run     = r;
    c.step    = 1'($urandom);
    c.opcode  = 2'($urandom);
    c.eq      = 1'($urandom);
    c.mem_ack = 1'($urandom);
    c.exp     = '0;
    return c;
  endfunction

  function automatic void push_idle(input logic r, input logic s);
    cyc_t c;
    c      = noise(r);
    c.step = s;
    c.exp  = mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    plan.push_back(c);
  endfunction

  // Expected cycles of one instruction starting in FETCH; w = mem_ack wait cycles
  function automatic void push_instr(input logic [1:0] op, input logic eqv, input int w,
                                     input logic run_first, input logic run_rest);
    cyc_t c;
    logic ld;
    logic sto;
    ld  = (op == 2'b01);
    sto = (op == 2'b10);
    c        = noise(run_first);
    c.opcode = op;
    c.exp    = mk(3'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    plan.push_back(c);
    c     = noise(run_rest);
    c.exp = mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    plan.push_back(c);
    c = noise(run_rest);
    if (op == 2'b11) begin
      c.eq  = eqv;
      c.exp = mk(3'd3, 1'b1, eqv, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      plan.push_back(c);
      exp_count = exp_count + 8'd1;
      return;
    end
    c.exp = mk(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ld | sto);
    plan.push_back(c);
    if (ld | sto) begin
      for (int i = 0; i <= w; i++) begin
        c         = noise(run_rest);
        c.mem_ack = (i == w);
        c.exp     = mk(3'd4, sto && (i == w), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ld, sto, 1'b0, 1'b0);
        plan.push_back(c);
        if (sto && (i == w)) begin
          exp_count = exp_count + 8'd1;
          return;
        end
      end
    end
    c     = noise(run_rest);
    c.exp = mk(3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ld, 1'b0);
    plan.push_back(c);
    exp_count = exp_count + 8'd1;
  endfunction

  function automatic int latency(input logic [1:0] op, input int w);
    case (op)
      2'b00:   return 4;
      2'b01:   return 5 + w;
      2'b10:   return 4 + w;
      default: return 3;
    endcase
  endfunction

  // Apply one planned cycle at the falling edge and sample just after
  task automatic drive(input cyc_t c, output logic [21:0] obs);
    @(negedge clk);
    run = c.run; step = c.step; opcode = c.opcode; eq = c.eq; mem_ack = c.mem_ack;
    #1;
    obs = {state, busy, done, pc_we, pc_src, ir_we, reg_we, mem_req, mem_rd, mem_wr,
           mem_to_reg, alu_src, instr_count};
  endtask

  task automatic test_reset();
    logic [21:0] obs;
    cyc_t c;
    int n = 0;
    run = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    obs = {state, busy, done, pc_we, pc_src, ir_we, reg_we, mem_req, mem_rd, mem_wr,
           mem_to_reg, alu_src, instr_count};
    checks++;
    if (obs !== 22'd0) begin
      errors++; $display("FAIL reset_hold: got %h expected %h", obs, 22'd0);
    end
    @(negedge clk);
    run = 1'b0; reset = 1'b1;
    exp_count = 8'd0;
    repeat (3) push_idle(1'b0, 1'b0);
    while (plan.size() > 0) begin
      c = plan.pop_front(); drive(c, obs); checks++; n++;
      if (obs !== c.exp) begin
        errors++; $display("FAIL reset_release cycle %0d: got %h expected %h", n, obs, c.exp);
      end
    end
  endtask

  task automatic test_add();
    logic [21:0] obs;
    cyc_t c;
    int n = 0, busy_cyc = 0;
    push_idle(1'b1, 1'b0);
    push_instr(2'b00, 1'b0, 0, 1'b1, 1'b0);
    push_idle(1'b0, 1'b0);
    while (plan.size() > 0) begin
      c = plan.pop_front(); drive(c, obs); checks++; n++;
      busy_cyc += int'(obs[18]);
      if (obs !== c.exp) begin
        errors++; $display("FAIL add cycle %0d: got %h expected %h", n, obs, c.exp);
      end
    end
    checks++;
    if (busy_cyc !== 4) begin
      errors++; $display("FAIL add_latency: got %0d expected 4", busy_cyc);
    end
  endtask

  task automatic test_load_wait();
    logic [21:0] obs;
    cyc_t c;
    int n = 0, busy_cyc = 0, req_cyc = 0;
    push_idle(1'b1, 1'b0);
    push_instr(2'b01, 1'b0, 3, 1'b1, 1'b0);
    push_idle(1'b0, 1'b0);
    while (plan.size() > 0) begin
      c = plan.pop_front(); drive(c, obs); checks++; n++;
      busy_cyc += int'(obs[18]);
      req_cyc  += int'(obs[12]);
      if (obs !== c.exp) begin
        errors++; $display("FAIL load_wait cycle %0d: got %h expected %h", n, obs, c.exp);
      end
    end
    checks++;
    if (busy_cyc !== 8 || req_cyc !== 4) begin
      errors++; $display("FAIL load_latency: got %0d/%0d expected 8/4", busy_cyc, req_cyc);
    end
  endtask

  task automatic test_branch();
    logic [21:0] obs;
    cyc_t c;
    int n = 0, busy_cyc = 0;
    push_idle(1'b1, 1'b0);
    push_instr(2'b11, 1'b0, 0, 1'b1, 1'b1);
    push_instr(2'b11, 1'b1, 0, 1'b1, 1'b0);
    push_idle(1'b0, 1'b0);
    while (plan.size() > 0) begin
      c = plan.pop_front(); drive(c, obs); checks++; n++;
      busy_cyc += int'(obs[18]);
      if (obs !== c.exp) begin
        errors++; $display("FAIL branch cycle %0d: got %h expected %h", n, obs, c.exp);
      end
    end
    checks++;
    if (busy_cyc !== 6) begin
      errors++; $display("FAIL branch_latency: got %0d expected 6", busy_cyc);
    end
  endtask

  task automatic test_back_to_back();
    logic [21:0] obs;
    cyc_t c;
    logic [1:0] op;
    int w, n = 0, busy_cyc = 0, exp_lat = 0;
    push_idle(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      op = 2'($urandom);
      w  = int'($urandom_range(4, 0));
      exp_lat += latency(op, w);
      push_instr(op, 1'($urandom), w, 1'b1, (i != 11));
    end
    push_idle(1'b0, 1'b0);
    while (plan.size() > 0) begin
      c = plan.pop_front(); drive(c, obs); checks++; n++;
      busy_cyc += int'(obs[18]);
      if (obs !== c.exp) begin
        errors++; $display("FAIL back_to_back cycle %0d: got %h expected %h", n, obs, c.exp);
      end
    end
    checks++;
    if (busy_cyc !== exp_lat) begin
      errors++; $display("FAIL back_to_back_latency: got %0d expected %0d", busy_cyc, exp_lat);
    end
  endtask

  task automatic test_run_drop();
    logic [21:0] obs;
    cyc_t c;
    int n = 0, busy_cyc = 0;
    push_idle(1'b1, 1'b0);
    push_instr(2'b01, 1'b0, 2, 1'b1, 1'b0);
    push_idle(1'b0, 1'b0);
    push_idle(1'b0, 1'b0);
    while (plan.size() > 0) begin
      c = plan.pop_front(); drive(c, obs); checks++; n++;
      busy_cyc += int'(obs[18]);
      if (obs !== c.exp) begin
        errors++; $display("FAIL run_drop cycle %0d: got %h expected %h", n, obs, c.exp);
      end
    end
    checks++;
    if (busy_cyc !== 7) begin
      errors++; $display("FAIL run_drop_latency: got %0d expected 7", busy_cyc);
    end
  endtask

  task automatic test_mem_reset();
    logic [21:0] obs;
    cyc_t c;
    int n = 0;
    push_idle(1'b1, 1'b0);
    push_instr(2'b01, 1'b0, 5, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      c = plan.pop_front(); drive(c, obs); checks++; n++;
      if (obs !== c.exp) begin
        errors++; $display("FAIL mem_reset_pre cycle %0d: got %h expected %h", n, obs, c.exp);
      end
    end
    plan.delete();
    checks++;
    if (mem_req !== 1'b1) begin
      errors++; $display("FAIL mem_reset_inmem: mem_req got %b expected 1", mem_req);
    end
    #2 reset = 1'b0;
    #1;
    obs = {state, busy, done, pc_we, pc_src, ir_we, reg_we, mem_req, mem_rd, mem_wr,
           mem_to_reg, alu_src, instr_count};
    checks++;
    if (obs !== 22'd0) begin
      errors++; $display("FAIL mem_reset_async: got %h expected %h", obs, 22'd0);
    end
    @(negedge clk);
    run = 1'b0; reset = 1'b1;
    exp_count = 8'd0;
    push_idle(1'b0, 1'b0);
    push_idle(1'b0, 1'b0);
    while (plan.size() > 0) begin
      c = plan.pop_front(); drive(c, obs); checks++; n++;
      if (obs !== c.exp) begin
        errors++; $display("FAIL mem_reset_post cycle %0d: got %h expected %h", n, obs, c.exp);
      end
    end
  endtask

  task automatic test_wrap();
    logic [21:0] obs;
    cyc_t c;
    int n = 0, dones = 0;
    push_idle(1'b1, 1'b0);
    for (int i = 0; i < 256; i++) begin
      push_instr(2'($urandom), 1'($urandom), int'($urandom_range(3, 0)), 1'b1, (i != 255));
    end
    push_idle(1'b0, 1'b0);
    while (plan.size() > 0) begin
      c = plan.pop_front(); drive(c, obs); checks++; n++;
      dones += int'(obs[17]);
      if (obs !== c.exp) begin
        errors++; $display("FAIL wrap cycle %0d: got %h expected %h", n, obs, c.exp);
      end
    end
    checks++;
    if (dones !== 256 || instr_count !== 8'd0) begin
      errors++; $display("FAIL wrap_count: dones %0d count %0d expected 256 and 0", dones, instr_count);
    end
  endtask

  task automatic test_step();
    logic [21:0] obs;
    cyc_t c;
    int n = 0, dones = 0, exp_dones;
`ifdef STEP_MODE_EN
    push_idle(1'b0, 1'b1);
    push_instr(2'($urandom), 1'($urandom), 1, 1'b0, 1'b0);
    push_idle(1'b0, 1'b0);
    push_idle(1'b0, 1'b0);
    push_idle(1'b0, 1'b1);
    push_instr(2'($urandom), 1'($urandom), 2, 1'b0, 1'b0);
    push_idle(1'b0, 1'b0);
    push_idle(1'b1, 1'b1);
    push_instr(2'b00, 1'b0, 0, 1'b1, 1'b0);
    push_idle(1'b0, 1'b0);
    exp_dones = 3;
`else
    repeat (3) push_idle(1'b0, 1'b1);
    push_idle(1'b0, 1'b0);
    exp_dones = 0;
`endif
    while (plan.size() > 0) begin
      c = plan.pop_front(); drive(c, obs); checks++; n++;
      dones += int'(obs[17]);
      if (obs !== c.exp) begin
        errors++; $display("FAIL step cycle %0d: got %h expected %h", n, obs, c.exp);
      end
    end
    checks++;
    if (dones !== exp_dones) begin
      errors++; $display("FAIL step_dones: got %0d expected %0d", dones, exp_dones);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_load_wait();
    test_branch();
    test_back_to_back();
    test_run_drop();
    test_mem_reset();
    test_wrap();
    test_step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
